// File: rtl/pe_uno_sched.sv
// Scheduler that sequences GEMM accumulate runs and Horner-ordered unary coefficient reads for a PE column.
// Optional busy-cycle performance counter is enabled by defining PE_SCHED_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// RUN     | issuing cmd_len cycles (coefficient reads for unary ops)
// DRAIN   | DRAIN_CYC cycles letting the PE pipeline empty
// DONE    | one-cycle completion pulse
module pe_uno_sched #(
  parameter int MUL_BW    = 16,
  parameter int LEN_BW    = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LEN_BW-1:0]   cmd_len,
  input  logic                abort,
  output logic [1:0]          gemm_uno,
  output logic                coef_rd_en,
  output logic [LEN_BW+1:0]   coef_addr,
  input  logic [MUL_BW-1:0]   coef_rdata,
  output logic [MUL_BW-1:0]   wc_o,
  output logic                wc_vld,
  output logic                busy,
  output logic                done
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_cnt
`endif
);

  localparam int DRN_BW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q, op_nxt;
  logic [LEN_BW-1:0]   cnt, cnt_nxt;
  logic [DRN_BW-1:0]   drn_cnt, drn_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= 2'b00;
      cnt     <= '0;
      drn_cnt <= '0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      cnt     <= cnt_nxt;
      drn_cnt <= drn_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    cnt_nxt    = cnt;
    drn_nxt    = drn_cnt;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    coef_rd_en = 1'b0;
    coef_addr  = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_nxt = cmd_op;
          if (cmd_len == '0) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = cmd_len - LEN_BW'(1);
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          // cnt counts down, so the highest term index is read first (Horner order)
          if (op_q != 2'b00) begin
            coef_rd_en = 1'b1;
            coef_addr  = {op_q, cnt};
          end
          if (cnt == '0) begin
            drn_nxt   = DRN_BW'(DRAIN_CYC - 1);
            state_nxt = S_DRAIN;
          end else begin
            cnt_nxt = cnt - LEN_BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          drn_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (drn_cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          drn_nxt = drn_cnt - DRN_BW'(1);
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mode select follows the next state so it lines up with RUN/DRAIN at the PE column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gemm_uno <= 2'b00;
    end else if (state_nxt == S_RUN || state_nxt == S_DRAIN) begin
      gemm_uno <= op_nxt;
    end else begin
      gemm_uno <= 2'b00;
    end
  end

  // coef_rdata is captured on the edge that closes the read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_o   <= '0;
      wc_vld <= 1'b0;
    end else if (coef_rd_en) begin
      wc_o   <= coef_rdata;
      wc_vld <= 1'b1;
    end else begin
      wc_o   <= '0;
      wc_vld <= 1'b0;
    end
  end

`ifdef PE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_uno_sched.sv
// Directed table-driven bench for pe_uno_sched plus hand-written abort, back-to-back and reset sequences.
module tb_pe_uno_sched;
  localparam int MUL_BW = 16;
  localparam int LEN_BW = 5;
  localparam int D      = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [LEN_BW-1:0] cmd_len = '0;
  logic              abort = 1'b0;
  logic [1:0]        gemm_uno;
  logic              coef_rd_en;
  logic [LEN_BW+1:0] coef_addr;
  logic [MUL_BW-1:0] coef_rdata;
  logic [MUL_BW-1:0] wc_o;
  logic              wc_vld;
  logic              busy;
  logic              done;
`ifdef PE_SCHED_PERF_EN
  logic [31:0]       perf_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] op;
    int         len;
    int         abort_k;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  pe_uno_sched #(.MUL_BW(MUL_BW), .LEN_BW(LEN_BW), .DRAIN_CYC(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .gemm_uno   (gemm_uno),
    .coef_rd_en (coef_rd_en),
    .coef_addr  (coef_addr),
    .coef_rdata (coef_rdata),
    .wc_o       (wc_o),
    .wc_vld     (wc_vld),
    .busy       (busy),
    .done       (done)
`ifdef PE_SCHED_PERF_EN
    ,
    .perf_cnt   (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [6:0] a);
    return {8'hA5, 1'b0, a};
  endfunction

  assign coef_rdata = coef_rd_en ? rom_f(coef_addr) : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_gemm_uno"}, gemm_uno, 0);
    chk({tag, "_rd_en"}, coef_rd_en, 0);
    chk({tag, "_addr"}, coef_addr, 0);
    chk({tag, "_wc_o"}, wc_o, 0);
    chk({tag, "_wc_vld"}, wc_vld, 0);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_cmd(input logic [1:0] op, input int len, input int abort_k, input int lat);
    logic [6:0]  a_exp;
    logic [15:0] w_exp;
    logic        rd_exp, wv_exp;
    chk("start_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_BW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      rd_exp = (k <= len) && (op != 2'b00);
      a_exp  = rd_exp ? {op, 5'(len - k)} : 7'd0;
      wv_exp = (op != 2'b00) && (k >= 2) && (k <= len + 1);
      w_exp  = wv_exp ? rom_f({op, 5'(len - k + 1)}) : 16'h0000;
      if (abort_k == lat && k == lat) abort = 1'b1;
      chk("run_busy", busy, 1);
      chk("run_ready", cmd_ready, 0);
      chk("run_done", done, (k == lat) ? 1 : 0);
      chk("run_gemm_uno", gemm_uno, (k < lat) ? op : 2'b00);
      chk("run_rd_en", coef_rd_en, rd_exp);
      chk("run_addr", coef_addr, a_exp);
      chk("run_wc_vld", wc_vld, wv_exp);
      chk("run_wc_o", wc_o, w_exp);
      if (abort_k == k && k < lat) begin
        abort = 1'b1;
        #1;
        chk("abort_rd_en", coef_rd_en, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_no_done", done, 0);
        chk("abort_gemm_uno", gemm_uno, 0);
        chk("abort_wc_vld", wc_vld, 0);
        @(posedge clk); #1;
        chk("abort_no_done_late", done, 0);
        return;
      end
    end
    @(posedge clk); #1;
    abort = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_ready", cmd_ready, 1);
    chk("end_done", done, 0);
    chk("end_gemm_uno", gemm_uno, 0);
  endtask

  initial begin
    // {op, len, abort cycle after accept (0 = none), done cycle after accept}
    vecs[0] = '{2'b10, 4,  0, 8};
    vecs[1] = '{2'b00, 6,  0, 10};
    vecs[2] = '{2'b11, 0,  0, 1};
    vecs[3] = '{2'b01, 8,  3, 12};
    vecs[4] = '{2'b10, 2,  0, 6};
    vecs[5] = '{2'b01, 31, 0, 35};
    vecs[6] = '{2'b11, 1,  0, 5};
    vecs[7] = '{2'b00, 0,  0, 1};
    vecs[8] = '{2'b00, 5,  7, 9};
    vecs[9] = '{2'b10, 1,  5, 5};

    #12;
    chk_reset_outputs("reset");
`ifdef PE_SCHED_PERF_EN
    chk("reset_perf", perf_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset");

    // abort while idle must be ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_ready", cmd_ready, 1);

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].abort_k, vecs[i].exp_lat);

`ifdef PE_SCHED_PERF_EN
    begin
      logic [31:0] p0;
      p0 = perf_cnt;
      run_cmd(2'b00, 2, 0, 6);
      chk("perf_gemm2", perf_cnt - p0, 6);
    end
`endif

    // back-to-back: cmd_valid stays high across two commands
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 5'd2;
    @(posedge clk); #1;
    cmd_op  = 2'b11;
    cmd_len = 5'd1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      chk("b2b_ready_low", cmd_ready, 0);
      chk("b2b_done1", done, (k == 6) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("b2b_gap_ready", cmd_ready, 1);
    chk("b2b_gap_busy", busy, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_gemm_uno", gemm_uno, 2'b11);
    chk("b2b_second_addr", coef_addr, 7'b11_00000);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("b2b_ready_low2", cmd_ready, 0);
      chk("b2b_done2", done, (k == 5) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("b2b_end_busy", busy, 0);

    // reset pulsed in the middle of DRAIN
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 5'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_gemm_uno", gemm_uno, 2'b10);
    chk("drain_rd_en", coef_rd_en, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_drain_reset");
`ifdef PE_SCHED_PERF_EN
    chk("mid_drain_perf", perf_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("after_reset_no_done", done, 0);
      chk("after_reset_idle", busy, 0);
    end

    run_cmd(2'b01, 3, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
